// File: rtl/cdc_fifo_gray_drain.sv
// rtl/cdc_fifo_gray_drain.sv - destination-side read endpoint of a gray-pointer async FIFO
// Synchronizes the write pointer, owns the gray read pointer, registers the head word, flushes one word per cycle.
module cdc_fifo_gray_drain #(
  parameter int unsigned WIDTH       = 1,
  parameter type         T           = logic [WIDTH-1:0],
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  T                     async_data_i [2**LOG_DEPTH],
  input  logic [LOG_DEPTH:0]   async_wptr_i,
  output logic [LOG_DEPTH:0]   async_rptr_o,
  output T                     data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 flush_i,
  output logic                 flush_busy_o,
  output logic [LOG_DEPTH:0]   level_o
);

  localparam int unsigned PW = LOG_DEPTH + 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < int'(PW); i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wptr_gray_sync;
  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] rptr_bin;
  logic          not_empty;

  state_e        state_q, state_d;
  logic [PW-1:0] target_q, target_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          valid_q, valid_d;
  T              data_q, data_d;
  logic          load;
  logic          pop;

  for (genvar i = 0; i < int'(PW); i++) begin : g_wptr_sync
    sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .rst_ni   (~rst_i),
      .serial_i (async_wptr_i[i]),
      .serial_o (wptr_gray_sync[i])
    );
  end

  assign wptr_bin  = gray2bin(wptr_gray_sync);
  assign rptr_bin  = gray2bin(rptr_q);
  assign not_empty = (wptr_bin != rptr_bin);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      rptr_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rptr_q   <= rptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Words written after the snapshot are beyond target and survive the flush.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (flush_i && not_empty) begin
          state_d  = FLUSH;
          target_d = wptr_bin;
        end
      end
      FLUSH: begin
        if (rptr_bin + PW'(1) == target_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush request beats any pending handshake: the held word is dropped.
  always_comb begin
    load    = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    if (state_q == IDLE) begin
      if (flush_i) begin
        valid_d = 1'b0;
      end else begin
        load = not_empty && (!valid_q || ready_i);
        if (load) begin
          valid_d = 1'b1;
          data_d  = async_data_i[rptr_bin[LOG_DEPTH-1:0]];
        end else if (valid_q && ready_i) begin
          valid_d = 1'b0;
        end
      end
    end
    pop    = load || (state_q == FLUSH);
    rptr_d = pop ? bin2gray(rptr_bin + PW'(1)) : rptr_q;
  end

  assign async_rptr_o = rptr_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign flush_busy_o = (state_q == FLUSH);
  assign level_o      = wptr_bin - rptr_bin;

endmodule

// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] reg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) reg_q <= '0;
    else         reg_q <= {reg_q[STAGES-2:0], serial_i};
  end

  assign serial_o = reg_q[STAGES-1];

endmodule

// File: tb/tb_cdc_fifo_gray_drain.sv
// tb/tb_cdc_fifo_gray_drain.sv - directed bench for cdc_fifo_gray_drain
// Models the source FIFO half; inputs driven and outputs sampled on the falling edge.
module tb_cdc_fifo_gray_drain;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] mem [8];
  logic [3:0] async_wptr_i;
  logic [3:0] async_rptr_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       flush_i;
  logic       flush_busy_o;
  logic [3:0] level_o;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] wcnt;
  logic [7:0] exp_q [$];

  cdc_fifo_gray_drain #(
    .WIDTH       (8),
    .LOG_DEPTH   (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .async_data_i (mem),
    .async_wptr_i (async_wptr_i),
    .async_rptr_o (async_rptr_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o),
    .level_o      (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return {g[3], g[3] ^ g[2], g[3] ^ g[2] ^ g[1], g[3] ^ g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic [7:0] d);
    mem[wcnt[2:0]] = d;
    wcnt = wcnt + 4'd1;
    async_wptr_i = b2g(wcnt);
  endtask

  task automatic step_ok(input string tag, input logic [3:0] prev);
    check(tag, 32'((async_rptr_o == prev) || (async_rptr_o == b2g(g2b(prev) + 4'd1))), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev;
    int got;
    int sent;
    int cyc;

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    wcnt = 4'd0;
    async_wptr_i = 4'd0;
    ready_i = 1'b1;
    flush_i = 1'b0;

    // Reset values
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_rptr", 32'(async_rptr_o), 0);
    check("rst_busy", 32'(flush_busy_o), 0);
    check("rst_level", 32'(level_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic transfer: 3-edge latency, consecutive delivery
    push(8'hA1);
    @(negedge clk_i);
    check("bas_valid_e1", 32'(valid_o), 0);
    push(8'hA2);
    @(negedge clk_i);
    check("bas_valid_e2", 32'(valid_o), 0);
    check("bas_level_e2", 32'(level_o), 1);
    push(8'hA3);
    @(negedge clk_i);
    check("bas_valid_e3", 32'(valid_o), 1);
    check("bas_data_a1", 32'(data_o), 32'h A1);
    @(negedge clk_i);
    check("bas_valid_a2", 32'(valid_o), 1);
    check("bas_data_a2", 32'(data_o), 32'h A2);
    @(negedge clk_i);
    check("bas_valid_a3", 32'(valid_o), 1);
    check("bas_data_a3", 32'(data_o), 32'h A3);
    check("bas_rptr", 32'(async_rptr_o), 2);
    check("bas_level", 32'(level_o), 0);
    @(negedge clk_i);
    check("bas_valid_end", 32'(valid_o), 0);

    // Full and backpressure
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(8'hB0 + 8'(i));
      @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    check("full_valid", 32'(valid_o), 1);
    check("full_data", 32'(data_o), 32'h B0);
    check("full_level", 32'(level_o), 7);
    ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_i);
      check("drain_valid", 32'(valid_o), 1);
      check("drain_data", 32'(data_o), 32'(8'hB0 + 8'(i)));
    end
    @(negedge clk_i);
    check("drain_valid_end", 32'(valid_o), 0);
    check("drain_level_end", 32'(level_o), 0);

    // Wrap-around with random write/ready bursts
    got = 0;
    sent = 0;
    prev = async_rptr_o;
    for (cyc = 0; cyc < 3000 && got < 40; cyc++) begin
      @(negedge clk_i);
      step_ok("wrap_rptr_step", prev);
      prev = async_rptr_o;
      ready_i = 1'($urandom_range(0, 1));
      if (valid_o && ready_i) begin
        check("wrap_data", 32'(data_o), 32'(exp_q.pop_front()));
        got++;
      end
      if (sent < 40 && $urandom_range(0, 2) != 0 &&
          4'(wcnt - g2b(async_rptr_o)) < 4'd8) begin
        push(8'(sent * 7 + 3));
        exp_q.push_back(8'(sent * 7 + 3));
        sent++;
      end
    end
    check("wrap_count", 32'(got), 40);
    ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("wrap_valid_end", 32'(valid_o), 0);
    check("wrap_level_end", 32'(level_o), 0);

    // Flush with a word written during the flush
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'hC0 + 8'(i));
      @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    check("fl_pre_valid", 32'(valid_o), 1);
    check("fl_pre_data", 32'(data_o), 32'h C0);
    check("fl_pre_level", 32'(level_o), 4);
    flush_i = 1'b1;
    prev = async_rptr_o;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      flush_i = 1'b0;
      check("fl_busy", 32'(flush_busy_o), 1);
      check("fl_valid", 32'(valid_o), 0);
      step_ok("fl_rptr_step", prev);
      prev = async_rptr_o;
      if (k == 1) push(8'hC5);
    end
    @(negedge clk_i);
    check("fl_busy_end", 32'(flush_busy_o), 0);
    check("fl_valid_end", 32'(valid_o), 0);
    step_ok("fl_rptr_step", prev);
    @(negedge clk_i);
    check("fl_c5_valid", 32'(valid_o), 1);
    check("fl_c5_data", 32'(data_o), 32'h C5);
    ready_i = 1'b1;
    @(negedge clk_i);
    check("fl_after_valid", 32'(valid_o), 0);
    check("fl_after_level", 32'(level_o), 0);

    // Flush on empty FIFO
    prev = async_rptr_o;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("ef_busy1", 32'(flush_busy_o), 0);
    @(negedge clk_i);
    check("ef_busy2", 32'(flush_busy_o), 0);
    check("ef_rptr", 32'(async_rptr_o), 32'(prev));

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    push(8'hD0);
    @(negedge clk_i);
    push(8'hD1);
    repeat (3) @(negedge clk_i);
    check("ar_pre_valid", 32'(valid_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_valid", 32'(valid_o), 0);
    check("ar_data", 32'(data_o), 0);
    check("ar_rptr", 32'(async_rptr_o), 0);
    check("ar_busy", 32'(flush_busy_o), 0);
    check("ar_level", 32'(level_o), 0);
    wcnt = 4'd0;
    async_wptr_i = 4'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ar_post_valid", 32'(valid_o), 0);
    push(8'hE0);
    repeat (3) @(negedge clk_i);
    check("ar_e0_valid", 32'(valid_o), 1);
    check("ar_e0_data", 32'(data_o), 32'h E0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
